// File: rtl/reg_bank_sched.sv
// reg_bank_sched: round-robin scheduler serialising load/add/sub/clear requests onto a four-register bank.
// Defining REG_BANK_SCHED_SAT_EN makes add/sub saturate instead of wrapping.
module reg_bank_sched #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int EXEC_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_idx,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic                 busy,
  output logic [DW-1:0]        a,
  output logic [DW-1:0]        b,
  output logic [DW-1:0]        c,
  output logic [DW-1:0]        d
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, w_win, w_j;
  logic [3:0] r_cnt;
  logic [1:0] r_idx, r_op;
  logic [DW-1:0] r_data, w_cur, w_add, w_sub, w_res;
  logic [DW-1:0] r_regs [4];
  logic [NREQ-1:0] r_gnt;
  logic r_done;
  logic w_take;
  assign busy = r_state == EXEC;
  assign w_take = r_state == IDLE && |req;
  assign gnt = r_gnt;
  assign done = r_done;
  assign a = r_regs[0];
  assign b = r_regs[1];
  assign c = r_regs[2];
  assign d = r_regs[3];
  assign w_cur = r_regs[r_idx];
`ifdef REG_BANK_SCHED_SAT_EN
  logic [DW:0] w_sum;
  assign w_sum = {1'b0, w_cur} + {1'b0, r_data};
  assign w_add = w_sum[DW] ? '1 : w_sum[DW-1:0];
  assign w_sub = w_cur < r_data ? '0 : w_cur - r_data;
`else
  assign w_add = w_cur + r_data;
  assign w_sub = w_cur - r_data;
`endif
  assign w_res = r_op == 2'b00 ? r_data : r_op == 2'b01 ? w_add : r_op == 2'b10 ? w_sub : '0;
  // winner: first requester at or after the pointer; scanning downward lets the nearest one overwrite
  always_comb begin
    w_win = r_ptr;
    w_j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = PW'((int'(r_ptr) + k) % NREQ);
      if (req[w_j]) w_win = w_j;
    end
  end
  // next state: leave IDLE on any request, leave EXEC once the counter has run out
  always_comb begin
    w_next = r_state == IDLE ? (|req ? EXEC : IDLE) : (r_cnt == 4'd0 ? IDLE : EXEC);
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // grant latching, execute countdown and register write-back
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_idx <= '0;
      r_op <= '0;
      r_data <= '0;
      r_gnt <= '0;
      r_done <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_gnt <= '0;
      r_done <= 1'b0;
      if (w_take) begin
        r_idx <= req_idx[2*w_win +: 2];
        r_op <= req_op[2*w_win +: 2];
        r_data <= req_data[DW*w_win +: DW];
        r_gnt <= NREQ'(1) << w_win;
        r_cnt <= 4'(EXEC_CYC - 1);
        r_ptr <= w_win == PW'(NREQ - 1) ? '0 : w_win + 1'b1;
      end else if (busy) begin
        if (r_cnt != 4'd0) r_cnt <= r_cnt - 1'b1;
        else begin
          r_regs[r_idx] <= w_res;
          r_done <= 1'b1;
        end
      end
    end
  end
endmodule
